arb_req_buffer: RTL and testbench
=================================

ARB_REQ_BUFFER -- requirements
Module: arb_req_buffer

Interface
REQ-001 Parameter DW, default 8, payload width in bits.
REQ-002 Parameter DEPTH, default 4, entries per requester FIFO; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 in_valid  input  4  per-port push request; bit i belongs to port i.
REQ-006 in_data  input  4*DW  per-port payload; port i occupies bits [i*DW +: DW].
REQ-007 in_ready  output  4  per-port space available; bit i is 1 when FIFO i can accept a push.
REQ-008 req3, req2, req1, req0  output  1 each  request lines to the downstream round-robin arbiter.
REQ-009 gnt3, gnt2, gnt1, gnt0  input  1 each  grant lines from the arbiter; one-hot or all zero when legal.
REQ-010 out_valid  output  1  a popped entry is presented this cycle.
REQ-011 out_src  output  2  index of the port that supplied out_data.
REQ-012 out_data  output  DW  popped payload.
REQ-013 err_multi  output  1  sticky flag: more than one grant was seen in one cycle.
REQ-014 err_spur  output  1  sticky flag: a grant arrived for an empty FIFO.

Function
REQ-015 The block SHALL hold four independent FIFOs, each DEPTH x DW, each with a registered occupancy count 0..DEPTH.
REQ-016 in_ready[i] SHALL be (count_i < DEPTH), decoded from registered state only; it SHALL NOT depend on a same-cycle pop.
REQ-017 A push to FIFO i SHALL occur on an edge where in_valid[i] && in_ready[i] are both 1.
REQ-018 reqi SHALL be (count_i != 0), decoded from registered state only; it has no combinational path from any input.
REQ-019 A pop of FIFO i SHALL occur on an edge where gnti is 1, count_i != 0, and no other gnt bit is 1.
REQ-020 A pop SHALL register the head entry: on the next cycle out_valid=1, out_src=i and out_data=head; out_valid is otherwise 0. Latency from grant to output is one cycle.
REQ-021 A grant held high over consecutive cycles SHALL pop once per cycle until FIFO i is empty.
REQ-022 reqi SHALL deassert on the cycle after the pop that empties FIFO i.
REQ-023 A simultaneous push and pop on the same FIFO (count strictly between 0 and DEPTH) SHALL leave count unchanged and preserve FIFO order.
REQ-024 A push on an empty FIFO together with a grant for that FIFO SHALL store the data without a pop, and SHALL set err_spur.
REQ-025 A grant for an empty FIFO SHALL not pop, not change state and not assert out_valid; it SHALL set err_spur.
REQ-026 Two or more gnt bits high in the same cycle SHALL suppress all pops that cycle and SHALL set err_multi.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 out_data SHALL hold its last value while out_valid=0.
REQ-029 There is no output backpressure; the consumer SHALL accept every out_valid beat.

Reset
REQ-030 While rst=0, all FIFO counts and pointers SHALL be 0, and out_valid, out_src, out_data, err_multi and err_spur SHALL be 0. As a result reqN=0 and in_ready=4'b1111.
REQ-031 Reset assertion in mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-032 Reset SHALL be the only way to clear err_multi and err_spur.
REQ-033 The first push SHALL be accepted on the first rising edge after rst returns to 1.

Structure
REQ-034 A shared package SHALL hold the number of ports (4), the width of the port index (2), and the defaults for DW and DEPTH.
REQ-035 A single sub-module, req_fifo (parameterised by DW and DEPTH, with push, pop, count, head and empty), SHALL be instantiated four times; the top level SHALL contain only the grant decode, the output register and the error flags.

Verification
REQ-036 Push 0xA1 then 0xA2 on port 0, with gnt0 held for 2 cycles -> out_data shows 0xA1 then 0xA2 on consecutive cycles with out_src=0; req0 falls the cycle after the second pop.
REQ-037 Fill port 2 with DEPTH entries and no grants -> in_ready[2]=0; a further push of 0xFF is dropped; granting 4 cycles returns the original 4 values in order.
REQ-038 Port 1 holds 2 entries; in one cycle push 0x55 and assert gnt1 -> count stays 2, out_data shows the old head, and 0x55 emerges third.
REQ-039 Assert gnt0 and gnt3 together with both FIFOs non-empty -> no pop, out_valid=0, err_multi=1 until reset.
REQ-040 Assert gnt2 with FIFO 2 empty -> out_valid=0, err_spur=1.
REQ-041 Pull rst low mid-burst with 3 entries buffered -> req lines drop immediately, in_ready=4'b1111, out_valid=0; after release, no stale data is output.

Source files
------------

// File: rtl/arb_req_buffer_pkg.sv
// Shared constants and helpers for the arbiter request buffer.
package arb_req_buffer_pkg;

    localparam int unsigned NumPorts     = 4;
    localparam int unsigned IdxW         = 2;
    localparam int unsigned DefaultDw    = 8;
    localparam int unsigned DefaultDepth = 4;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NumPorts-1:0] v);
        return (v & (v - NumPorts'(1))) != '0;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-clock FIFO with registered occupancy; push and pop are gated internally
// against full/empty so callers may drive them unconditionally.
module req_fifo
    import arb_req_buffer_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head,
    output logic          empty
);

    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != Full);
    assign pop_ok  = pop && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];
    assign empty = (count_q == '0);

endmodule

// File: rtl/arb_req_buffer.sv
// Four per-port request FIFOs feeding a round-robin arbiter; granted heads are
// popped into a single registered output, with sticky flags for illegal grants.
module arb_req_buffer
    import arb_req_buffer_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumPorts-1:0]      in_valid,
    input  logic [NumPorts*DW-1:0]   in_data,
    output logic [NumPorts-1:0]      in_ready,
    output logic                     req3,
    output logic                     req2,
    output logic                     req1,
    output logic                     req0,
    input  logic                     gnt3,
    input  logic                     gnt2,
    input  logic                     gnt1,
    input  logic                     gnt0,
    output logic                     out_valid,
    output logic [IdxW-1:0]          out_src,
    output logic [DW-1:0]            out_data,
    output logic                     err_multi,
    output logic                     err_spur
);

    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [NumPorts-1:0] gnt, pop, push, empty;
    logic [CW-1:0]       count [NumPorts];
    logic [DW-1:0]       head  [NumPorts];
    logic                multi, spur_hit;
    logic [IdxW-1:0]     sel_src;
    logic [DW-1:0]       sel_data;

    logic                out_valid_q;
    logic [IdxW-1:0]     out_src_q;
    logic [DW-1:0]       out_data_q;
    logic                err_multi_q, err_spur_q;

    assign gnt      = {gnt3, gnt2, gnt1, gnt0};
    assign multi    = multi_hot(gnt);
    assign spur_hit = |(gnt & empty);

    for (genvar i = 0; i < NumPorts; i++) begin : g_fifo
        // Pops are qualified by registered emptiness, so a push into an empty
        // FIFO alongside its grant is stored, not forwarded.
        assign in_ready[i] = (count[i] < Full);
        assign push[i]     = in_valid[i] && in_ready[i];
        assign pop[i]      = gnt[i] && !multi && !empty[i];

        req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (in_data[i*DW +: DW]),
            .count (count[i]),
            .head  (head[i]),
            .empty (empty[i])
        );
    end

    assign {req3, req2, req1, req0} = ~empty;

    always_comb begin
        sel_src  = '0;
        sel_data = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (pop[i]) begin
                sel_src  = IdxW'(i);
                sel_data = head[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_data_q  <= '0;
            err_multi_q <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            out_valid_q <= |pop;
            if (|pop) begin
                out_src_q  <= sel_src;
                out_data_q <= sel_data;
            end
            if (multi)    err_multi_q <= 1'b1;
            if (spur_hit) err_spur_q  <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_data  = out_data_q;
    assign err_multi = err_multi_q;
    assign err_spur  = err_spur_q;

endmodule

// File: tb/tb_arb_req_buffer.sv
// Directed and randomized checks of arb_req_buffer against a queue-based model.
module tb_arb_req_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        req3, req2, req1, req0;
    logic        gnt3, gnt2, gnt1, gnt0;
    logic        out_valid;
    logic [1:0]  out_src;
    logic [7:0]  out_data;
    logic        err_multi, err_spur;

    arb_req_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req3      (req3),
        .req2      (req2),
        .req1      (req1),
        .req0      (req0),
        .gnt3      (gnt3),
        .gnt2      (gnt2),
        .gnt1      (gnt1),
        .gnt0      (gnt0),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_data  (out_data),
        .err_multi (err_multi),
        .err_spur  (err_spur)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one queue per port plus the last presented beat.
    logic [7:0] mq [4][$];
    logic [7:0] m_data;
    logic [1:0] m_src;
    bit         m_valid, m_multi, m_spur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_data  = '0;
        m_src   = '0;
        m_valid = 1'b0;
        m_multi = 1'b0;
        m_spur  = 1'b0;
    endtask

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(mq[i].size() < DEPTH));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("req%0d", i), 32'(dut.req0 & (i == 0) | req1 & (i == 1) |
                                             req2 & (i == 2) | req3 & (i == 3)),
                32'(mq[i].size() != 0));
        end
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_src",   32'(out_src),   32'(m_src));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("err_multi", 32'(err_multi), 32'(m_multi));
        chk("err_spur",  32'(err_spur),  32'(m_spur));
    endtask

    // One clock cycle: drive, check registered-state outputs, advance model, check outputs.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        int n;
        int who;
        bit can_push [4];
        n   = 0;
        who = 0;
        in_valid = v;
        in_data  = d;
        {gnt3, gnt2, gnt1, gnt0} = g;
        #1;
        check_state();
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                n++;
                who = i;
            end
            can_push[i] = v[i] && (mq[i].size() < DEPTH);
        end
        m_valid = 1'b0;
        if (n > 1) m_multi = 1'b1;
        for (int i = 0; i < 4; i++) if (g[i] && mq[i].size() == 0) m_spur = 1'b1;
        if (n == 1 && mq[who].size() != 0) begin
            m_data  = mq[who].pop_front();
            m_src   = 2'(who);
            m_valid = 1'b1;
        end
        for (int i = 0; i < 4; i++) if (can_push[i]) mq[i].push_back(d[i*8 +: 8]);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [3:0]  rv, rg;
        logic [31:0] rd;
        int          r;

        rst = 1'b0;
        in_valid = '0;
        in_data  = '0;
        {gnt3, gnt2, gnt1, gnt0} = '0;
        model_reset();
        #12;
        chk("reset in_ready", 32'(in_ready), 32'hF);
        chk("reset req", 32'({req3, req2, req1, req0}), 32'h0);
        check_out();

        // First push lands on the first edge after release.
        rst = 1'b1;
        cycle(4'b0001, 32'h0000_00A1, 4'b0000);
        cycle(4'b0001, 32'h0000_00A2, 4'b0000);
        cycle(4'b0000, 32'h0, 4'b0001);
        chk("p0 first pop", 32'(out_data), 32'hA1);
        cycle(4'b0000, 32'h0, 4'b0001);
        chk("p0 second pop", 32'(out_data), 32'hA2);
        chk("p0 src", 32'(out_src), 32'h0);
        chk("req0 falls", 32'(req0), 32'h0);

        // Fill port 2, overflow push dropped, drain in order.
        for (int k = 0; k < DEPTH; k++) cycle(4'b0100, 32'(8'hC0 + k) << 16, 4'b0000);
        chk("full in_ready2", 32'(in_ready[2]), 32'h0);
        cycle(4'b0100, 32'h00FF_0000, 4'b0000);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(4'b0000, 32'h0, 4'b0100);
            chk("p2 drain", 32'(out_data), 32'(8'hC0 + k));
        end

        // Simultaneous push and pop on port 1.
        cycle(4'b0010, 32'h0000_1100, 4'b0000);
        cycle(4'b0010, 32'h0000_2200, 4'b0000);
        cycle(4'b0010, 32'h0000_5500, 4'b0010);
        chk("p1 old head", 32'(out_data), 32'h11);
        cycle(4'b0000, 32'h0, 4'b0010);
        cycle(4'b0000, 32'h0, 4'b0010);
        chk("p1 pushed third", 32'(out_data), 32'h55);

        // Spurious grant on empty port 2.
        cycle(4'b0000, 32'h0, 4'b0100);
        chk("spur flag", 32'(err_spur), 32'h1);

        // Multiple grants suppress pops.
        cycle(4'b1001, 32'hD300_00D0, 4'b0000);
        cycle(4'b0000, 32'h0, 4'b1001);
        chk("multi no pop", 32'(out_valid), 32'h0);
        cycle(4'b0000, 32'h0, 4'b0000);
        chk("multi sticky", 32'(err_multi), 32'h1);

        // Asynchronous reset mid-burst.
        cycle(4'b0010, 32'h0000_6100, 4'b0000);
        cycle(4'b0010, 32'h0000_6200, 4'b0000);
        cycle(4'b0010, 32'h0000_6300, 4'b0000);
        cycle(4'b0000, 32'h0, 4'b0010);
        in_valid = '0;
        {gnt3, gnt2, gnt1, gnt0} = '0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async req", 32'({req3, req2, req1, req0}), 32'h0);
        chk("async in_ready", 32'(in_ready), 32'hF);
        check_out();
        @(negedge clk);
        rst = 1'b1;
        cycle(4'b0000, 32'h0, 4'b0000);
        cycle(4'b0000, 32'h0, 4'b0010);
        chk("no stale", 32'(out_valid), 32'h0);
        cycle(4'b0010, 32'h0000_7700, 4'b0000);
        cycle(4'b0000, 32'h0, 4'b0010);

        // Randomized traffic, grants mostly legal.
        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom_range(0, 15));
            rd = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r < 5)      rg = 4'(1 << $urandom_range(0, 3));
            else if (r < 8) rg = 4'b0000;
            else            rg = 4'($urandom_range(0, 15));
            cycle(rv, rd, rg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
